// File: rtl/calc_pkg.sv
// Shared types for the accumulator calculator: ALU opcodes, queued command record
// and scheduler FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_EQ  = 2'd3
  } op_e;

  typedef struct packed {
    logic       id;
    op_e        op;
    logic [7:0] num;
  } calc_cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small synchronous FIFO of calc_cmd_t records with wrapping pointers and an
// occupancy count; pushes when full and pops when empty are dropped.
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic                         push,
  input  calc_cmd_t                    push_cmd,
  input  logic                         pop,
  output calc_cmd_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  calc_cmd_t     mem_q [DEPTH];

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Shares the accumulator ALU between two requesters: round-robin arbiter into a
// command FIFO, then an issue FSM that runs one command at a time with a timeout.
module calc_cmd_scheduler
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        Reset,
  input  logic                        req0_valid,
  input  logic [1:0]                  req0_op,
  input  logic [7:0]                  req0_num,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [1:0]                  req1_op,
  input  logic [7:0]                  req1_num,
  output logic                        req1_ready,
  output logic                        alu_go,
  output logic [1:0]                  alu_op,
  output logic [7:0]                  alu_num,
  input  logic                        alu_done,
  input  logic [7:0]                  alu_result,
  output logic                        rsp_valid,
  output logic                        rsp_id,
  output logic [7:0]                  rsp_result,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  logic         push, pop, full, empty;
  calc_cmd_t    push_cmd, head;
  logic         rr_q, rr_d;
  sched_state_e state_q, state_d;
  logic         alu_go_q, alu_go_d;
  op_e          alu_op_q, alu_op_d;
  logic [7:0]   alu_num_q, alu_num_d;
  logic         rsp_id_q, rsp_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [7:0]   rsp_result_q, rsp_result_d;
  logic         rsp_err_q, rsp_err_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;

  calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .Reset    (Reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  // Ready is withheld whenever full, even if the head pops this cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    push       = 1'b0;
    push_cmd   = '0;
    rr_d       = rr_q;
    if (!full) begin
      if (req0_valid && (!req1_valid || !rr_q)) begin
        req0_ready = 1'b1;
        push       = 1'b1;
        push_cmd   = '{id: 1'b0, op: op_e'(req0_op), num: req0_num};
        rr_d       = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
        push       = 1'b1;
        push_cmd   = '{id: 1'b1, op: op_e'(req1_op), num: req1_num};
        rr_d       = 1'b0;
      end
    end
  end

  // NOTE: every _d starts from its hold value before any branch, so no path
  // leaves a combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    alu_go_d     = 1'b0;
    alu_op_d     = alu_op_q;
    alu_num_d    = alu_num_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    tmo_d        = tmo_q;
    tmo_inc      = (tmo_q == TIMEOUT_C) ? tmo_q : tmo_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          alu_op_d  = head.op;
          alu_num_d = head.num;
          rsp_id_d  = head.id;
          alu_go_d  = 1'b1;
          tmo_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done that coincides with the go strobe belongs to an earlier operation.
        if (!alu_go_q) begin
          if (alu_done) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_err_d    = 1'b0;
            state_d      = S_IDLE;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_inc == TIMEOUT_C) begin
              rsp_valid_d  = 1'b1;
              rsp_result_d = '0;
              rsp_err_d    = 1'b1;
              state_d      = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rr_q         <= 1'b0;
      state_q      <= S_IDLE;
      alu_go_q     <= 1'b0;
      alu_op_q     <= OP_ADD;
      alu_num_q    <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      rr_q         <= rr_d;
      state_q      <= state_d;
      alu_go_q     <= alu_go_d;
      alu_op_q     <= alu_op_d;
      alu_num_q    <= alu_num_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign alu_go     = alu_go_q;
  assign alu_op     = alu_op_q;
  assign alu_num    = alu_num_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Directed bench for calc_cmd_scheduler: queue-fed requesters, a scriptable ALU
// responder and event logs checked against hand-derived cycle numbers.
module tb_calc_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int LOGN    = 8192;

  typedef struct { logic [1:0] op; logic [7:0] num; } req_t;
  typedef struct { int id; logic [1:0] op; logic [7:0] num; int cyc; } ev_t;
  typedef struct { int id; logic [7:0] res; logic err; int cyc; } rsp_t;

  logic       clock = 1'b0;
  logic       Reset;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_num = '0, req1_num = '0;
  logic       req0_ready, req1_ready;
  logic       alu_go;
  logic [1:0] alu_op;
  logic [7:0] alu_num;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;
  logic [2:0] fifo_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   viol     = 0;
  int   last_go  = -1;
  int   alu_delay = 0;
  logic [7:0] last_num = '0;
  logic [7:0] alu_key  = '0;
  bit   done_at [LOGN];
  logic [2:0] count_log [LOGN];

  req_t q0[$], q1[$];
  ev_t  grant_q[$], go_q[$];
  rsp_t rsp_q[$];

  calc_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_num   (req0_num),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_num   (req1_num),
    .req1_ready (req1_ready),
    .alu_go     (alu_go),
    .alu_op     (alu_op),
    .alu_num    (alu_num),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  assign alu_result = last_num ^ alu_key;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc = cyc + 1;

  // Requester drivers: present the queue head until the monitor sees it accepted.
  always @(posedge clock) begin
    #1;
    if (!Reset && q0.size() > 0) begin
      req0_valid = 1'b1; req0_op = q0[0].op; req0_num = q0[0].num;
    end else req0_valid = 1'b0;
    if (!Reset && q1.size() > 0) begin
      req1_valid = 1'b1; req1_op = q1[0].op; req1_num = q1[0].num;
    end else req1_valid = 1'b0;
  end

  // ALU responder: done after alu_delay cycles (0 = never) or on scripted cycles.
  always @(posedge clock) begin
    #1;
    alu_done = (alu_delay > 0 && last_go >= 0 && cyc == last_go + alu_delay) ||
               (cyc < LOGN && done_at[cyc]);
  end

  always @(negedge clock) begin
    if (!Reset) begin
      if (cyc < LOGN) count_log[cyc] = fifo_count;
      if (req0_ready && req1_ready) viol++;
      if (fifo_count == 3'(DEPTH) && (req0_ready || req1_ready)) viol++;
      if (req0_valid && req0_ready) begin
        grant_q.push_back('{id: 0, op: req0_op, num: req0_num, cyc: cyc});
        q0.delete(0);
      end
      if (req1_valid && req1_ready) begin
        grant_q.push_back('{id: 1, op: req1_op, num: req1_num, cyc: cyc});
        q1.delete(0);
      end
      if (alu_go) begin
        go_q.push_back('{id: 0, op: alu_op, num: alu_num, cyc: cyc});
        last_go  = cyc;
        last_num = alu_num;
      end
      if (rsp_valid)
        rsp_q.push_back('{id: int'(rsp_id), res: rsp_result, err: rsp_err, cyc: cyc});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'b0, req0_ready, req1_ready, alu_go, alu_op, alu_num, rsp_valid, rsp_id,
            rsp_result, rsp_err, busy, fifo_count};
  endfunction

  task automatic clear_logs();
    grant_q.delete(); go_q.delete(); rsp_q.delete(); viol = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    q0.delete(); q1.delete();
    tick(2);
    check("reset_outputs_zero", outs(), 32'h0);
    Reset = 1'b0;
    tick(1);
    clear_logs();
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && rsp_q.size() < n; k++) tick();
    check(tag, rsp_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300 && (busy || q0.size() > 0 || q1.size() > 0); k++) tick();
    check(tag, busy, 1'b0);
    tick(2);
    clear_logs();
  endtask

  task automatic push_req(input int who, input logic [1:0] op, input logic [7:0] num);
    req_t r;
    r.op = op; r.num = num;
    if (who == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_c, g1, p, mx, n;
    Reset = 1'b1;
    tick(3);
    check("por_outputs_zero", outs(), 32'h0);
    Reset = 1'b0;
    tick(2);

    // 1: reset while one command waits on the ALU and three are queued
    alu_delay = 0;
    for (int i = 0; i < 4; i++) push_req(1, 2'((i % 3) + 1), 8'(8'h11 * (i + 1)));
    for (int k = 0; k < 30 && !(fifo_count == 3'd3 && go_q.size() == 1); k++) tick();
    check("t1_inflight_go", go_q.size(), 1);
    check("t1_queued", fifo_count, 3'd3);
    do_reset();
    tick(20);
    check("t1_no_rsp", rsp_q.size(), 0);
    check("t1_no_go", go_q.size(), 0);
    check("t1_idle_empty", {busy, fifo_count}, 4'b0);

    // 2: single command, ALU answers one cycle after go
    alu_delay = 1; alu_key = 8'h00;
    push_req(0, 2'd0, 8'h05);
    wait_rsp("t2_rsp_count", 1, 20);
    if (rsp_q.size() == 1 && go_q.size() == 1 && grant_q.size() == 1) begin
      check("t2_go_latency", go_q[0].cyc - grant_q[0].cyc, 2);
      check("t2_rsp_latency", rsp_q[0].cyc - go_q[0].cyc, 2);
      check("t2_go_op", go_q[0].op, 2'd0);
      check("t2_rsp_id", rsp_q[0].id, 0);
      check("t2_rsp_result", rsp_q[0].res, 8'h05);
      check("t2_rsp_err", rsp_q[0].err, 1'b0);
    end
    wait_idle("t2_idle");

    // 3: both requesters contend with six commands each
    do_reset();
    alu_delay = 1; alu_key = 8'h3C;
    start_c = cyc;
    for (int i = 0; i < 6; i++) begin
      push_req(0, 2'(i % 4), 8'(8'h10 + i));
      push_req(1, 2'((i + 1) % 4), 8'(8'h80 + i));
    end
    wait_rsp("t3_rsp_count", 12, 300);
    check("t3_ready_rules", viol, 0);
    mx = 0;
    for (int c = start_c; c < cyc && c < LOGN; c++) if (int'(count_log[c]) > mx) mx = int'(count_log[c]);
    check("t3_fifo_filled", mx, DEPTH);
    if (rsp_q.size() == 12 && grant_q.size() == 12 && go_q.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check("t3_grant_alternates", grant_q[i].id, i % 2);
        check("t3_go_op", go_q[i].op, grant_q[i].op);
        check("t3_go_num", go_q[i].num, grant_q[i].num);
        check("t3_rsp_id", rsp_q[i].id, grant_q[i].id);
        check("t3_rsp_result", rsp_q[i].res, grant_q[i].num ^ 8'h3C);
        check("t3_rsp_err", rsp_q[i].err, 1'b0);
      end
      for (int i = 0; i < 11; i++) check("t3_go_spacing", go_q[i + 1].cyc - go_q[i].cyc, 3);
    end
    wait_idle("t3_idle");

    // 4: full FIFO refuses req1 in the pop cycle and accepts it one cycle later
    alu_delay = 8; alu_key = 8'h00;
    for (int i = 0; i < 5; i++) push_req(0, 2'd1, 8'(8'h20 + i));
    for (int k = 0; k < 20 && !(fifo_count == 3'd4 && q0.size() == 0); k++) tick();
    check("t4_full", fifo_count, 3'd4);
    push_req(1, 2'd2, 8'h77);
    wait_rsp("t4_rsp_count", 6, 200);
    check("t4_ready_rules", viol, 0);
    g1 = -1;
    foreach (grant_q[i]) if (grant_q[i].id == 1) g1 = grant_q[i].cyc;
    if (go_q.size() >= 2 && g1 >= 0) begin
      p = go_q[1].cyc - 1;
      check("t4_grant_after_pop", g1, p + 1);
      check("t4_count_at_pop", count_log[p], 3'd4);
      check("t4_count_after_pop", count_log[p + 1], 3'd3);
      check("t4_count_after_push", count_log[p + 2], 3'd4);
    end
    if (rsp_q.size() == 6) begin
      check("t4_last_rsp_id", rsp_q[5].id, 1);
      check("t4_last_rsp_result", rsp_q[5].res, 8'h77);
    end
    wait_idle("t4_idle");

    // 5: ALU never answers; both commands time out in turn
    alu_delay = 0; alu_key = 8'hFF;
    push_req(1, 2'd3, 8'h00);
    push_req(1, 2'd0, 8'h01);
    wait_rsp("t5_rsp_count", 2, 80);
    if (rsp_q.size() == 2 && go_q.size() == 2) begin
      check("t5_timeout_cycle", rsp_q[0].cyc - go_q[0].cyc, TIMEOUT + 1);
      check("t5_err", rsp_q[0].err, 1'b1);
      check("t5_result_zero", rsp_q[0].res, 8'h00);
      check("t5_rsp_id", rsp_q[0].id, 1);
      check("t5_next_issue", go_q[1].cyc, rsp_q[0].cyc + 1);
      check("t5_second_err", {rsp_q[1].err, rsp_q[1].res}, 9'h100);
    end
    wait_idle("t5_idle");

    // 6: stray done pulses in IDLE and coincident with go are ignored
    alu_delay = 0; alu_key = 8'h00;
    done_at[cyc + 2] = 1'b1;
    done_at[cyc + 3] = 1'b1;
    tick(6);
    check("t6_idle_stray", rsp_q.size(), 0);
    push_req(0, 2'd1, 8'h42);
    for (int k = 0; k < 10 && grant_q.size() == 0; k++) tick();
    check("t6_granted", grant_q.size(), 1);
    if (grant_q.size() == 1) begin
      n = grant_q[0].cyc;
      done_at[n + 2] = 1'b1;
      done_at[n + 4] = 1'b1;
      done_at[n + 6] = 1'b1;
      done_at[n + 7] = 1'b1;
      tick(15);
      check("t6_one_rsp", rsp_q.size(), 1);
      if (rsp_q.size() == 1 && go_q.size() == 1) begin
        check("t6_go_cycle", go_q[0].cyc, n + 2);
        check("t6_rsp_cycle", rsp_q[0].cyc, n + 5);
        check("t6_rsp_result", rsp_q[0].res, 8'h42);
        check("t6_rsp_err", rsp_q[0].err, 1'b0);
      end
    end
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
